// File: rtl/pwc_pkg.sv
// pwc_pkg: shared defaults and helpers for the pointwise-convolution PE.
//   PWC_DWIDTH / PWC_P_CH / PWC_P_OC / PWC_GRP_W : default parameter values
//   psum_width()  : width of one P_CH-wide signed dot product
//   acc_width()   : accumulator width (dot product plus group growth)
//   requant_sat() : round-half-up arithmetic right shift, then saturate to dw bits
package pwc_pkg;

    localparam int PWC_DWIDTH = 8;
    localparam int PWC_P_CH   = 32;
    localparam int PWC_P_OC   = 4;
    localparam int PWC_GRP_W  = 4;

    function automatic int psum_width(input int dw, input int pch);
        return 2 * dw + $clog2(pch);
    endfunction

    function automatic int acc_width(input int dw, input int pch, input int gw);
        return psum_width(dw, pch) + gw;
    endfunction

    // Works on a 64-bit container so the rounding add can never wrap; the
    // caller keeps the low dw bits, which hold the saturated two's-complement value.
    function automatic logic signed [63:0] requant_sat(input logic signed [63:0] acc,
                                                       input logic [4:0]         shift,
                                                       input int                 dw);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r = acc;
        if (shift != 5'd0)
            r = r + (64'sd1 <<< (shift - 5'd1));
        r  = r >>> shift;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (r > hi)
            r = hi;
        else if (r < lo)
            r = lo;
        return r;
    endfunction

endpackage

// File: rtl/pwc_dot_p.sv
// pwc_dot_p: one P_CH-wide signed dot product, two register stages.
//   Stage A registers the P_CH products, stage B registers their sum.
// Ports:
//   clk, reset : clock, async active-high reset
//   en         : advance both stages (low while the PE output is stalled)
//   feature    : P_CH signed DWIDTH features, ch0 in LSBs
//   weight     : P_CH signed DWIDTH weights for one output channel, ch0 in LSBs
//   psum       : registered signed dot product
module pwc_dot_p
    import pwc_pkg::*;
#(
    parameter int DWIDTH = PWC_DWIDTH,
    parameter int P_CH   = PWC_P_CH
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       en,
    input  logic [DWIDTH*P_CH-1:0]                     feature,
    input  logic [DWIDTH*P_CH-1:0]                     weight,
    output logic signed [psum_width(DWIDTH, P_CH)-1:0] psum
);

    localparam int PS_W = psum_width(DWIDTH, P_CH);

    logic signed [2*DWIDTH-1:0] prod_q [P_CH];
    logic signed [PS_W-1:0]     sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < P_CH; c++)
                prod_q[c] <= '0;
        end else if (en) begin
            for (int c = 0; c < P_CH; c++)
                prod_q[c] <= $signed(feature[c*DWIDTH +: DWIDTH]) *
                             $signed(weight[c*DWIDTH +: DWIDTH]);
        end
    end

    always_comb begin
        sum = '0;
        for (int c = 0; c < P_CH; c++)
            sum = sum + PS_W'(prod_q[c]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            psum <= '0;
        else if (en)
            psum <= sum;
    end

endmodule

// File: rtl/pwc_pe_acc.sv
// pwc_pe_acc: pointwise (1x1) convolution PE with group accumulation.
//   Each accepted beat multiplies P_CH features by P_OC weight vectors; beats are
//   accumulated over cfg_num_groups groups, then requantised, saturated and
//   streamed out. Accept-to-out_valid latency is two clocks.
// Ports:
//   clk, reset        : clock, async active-high reset
//   cfg_num_groups    : groups per tile (0 behaves as 1), latched on group 0
//   cfg_shift         : requant right shift, latched on group 0
//   in_valid/in_ready : input beat handshake
//   in_feature        : P_CH signed features, ch0 in LSBs
//   in_weight         : P_OC x P_CH weights, oc-major
//   out_valid/out_ready, out_data : result stream, oc0 in LSBs
// Build option: define PWC_RELU_EN to clamp negative results to zero.
module pwc_pe_acc
    import pwc_pkg::*;
#(
    parameter int DWIDTH = PWC_DWIDTH,
    parameter int P_CH   = PWC_P_CH,
    parameter int P_OC   = PWC_P_OC,
    parameter int GRP_W  = PWC_GRP_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [GRP_W-1:0]              cfg_num_groups,
    input  logic [4:0]                    cfg_shift,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DWIDTH*P_CH-1:0]        in_feature,
    input  logic [DWIDTH*P_CH*P_OC-1:0]   in_weight,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DWIDTH*P_OC-1:0]        out_data
);

    localparam int ACC_W = acc_width(DWIDTH, P_CH, GRP_W);
    localparam int PS_W  = psum_width(DWIDTH, P_CH);

    logic                    stall;
    logic                    en;
    logic                    accept;
    logic [GRP_W-1:0]        grp_cnt;
    logic [GRP_W-1:0]        ng_lat;
    logic [4:0]              sh_lat;
    logic [GRP_W-1:0]        ng_cur;
    logic [4:0]              sh_cur;
    logic                    first;
    logic                    last;

    // tile flags travel alongside the data through both dot-product stages
    logic                    s1_valid;
    logic                    s1_last;
    logic                    s1_first;
    logic [4:0]              s1_shift;
    logic                    psum_valid;
    logic                    psum_last;
    logic                    psum_first;
    logic [4:0]              psum_shift;

    logic signed [PS_W-1:0]  psum     [P_OC];
    logic signed [ACC_W-1:0] acc      [P_OC];
    logic signed [ACC_W-1:0] acc_next [P_OC];
    logic [DWIDTH-1:0]       lane;
    logic [DWIDTH*P_OC-1:0]  out_next;

    assign stall    = out_valid & ~out_ready;
    assign en       = ~stall;
    assign in_ready = en;
    assign accept   = in_valid & en;

    always_comb begin
        first  = (grp_cnt == '0);
        ng_cur = ng_lat;
        sh_cur = sh_lat;
        if (first) begin
            ng_cur = (cfg_num_groups == '0) ? GRP_W'(1) : cfg_num_groups;
            sh_cur = cfg_shift;
        end
        last = (grp_cnt == ng_cur - GRP_W'(1));
    end

    for (genvar k = 0; k < P_OC; k++) begin : g_oc
        pwc_dot_p #(
            .DWIDTH (DWIDTH),
            .P_CH   (P_CH)
        ) u_dot (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .feature (in_feature),
            .weight  (in_weight[k*DWIDTH*P_CH +: DWIDTH*P_CH]),
            .psum    (psum[k])
        );
    end

    always_comb begin
        out_next = '0;
        lane     = '0;
        for (int k = 0; k < P_OC; k++) begin
            acc_next[k] = (psum_first ? {ACC_W{1'b0}} : acc[k]) + ACC_W'(psum[k]);
            lane = DWIDTH'(requant_sat(64'(acc_next[k]), psum_shift, DWIDTH));
`ifdef PWC_RELU_EN
            if (lane[DWIDTH-1])
                lane = '0;
`endif
            out_next[k*DWIDTH +: DWIDTH] = lane;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grp_cnt    <= '0;
            ng_lat     <= GRP_W'(1);
            sh_lat     <= '0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_first   <= 1'b0;
            s1_shift   <= '0;
            psum_valid <= 1'b0;
            psum_last  <= 1'b0;
            psum_first <= 1'b0;
            psum_shift <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            for (int k = 0; k < P_OC; k++)
                acc[k] <= '0;
        end else begin
            if (accept) begin
                grp_cnt <= last ? '0 : grp_cnt + GRP_W'(1);
                if (first) begin
                    ng_lat <= ng_cur;
                    sh_lat <= cfg_shift;
                end
            end
            if (en) begin
                s1_valid   <= accept;
                s1_last    <= accept & last;
                s1_first   <= first;
                s1_shift   <= sh_cur;
                psum_valid <= s1_valid;
                psum_last  <= s1_last;
                psum_first <= s1_first;
                psum_shift <= s1_shift;
                if (psum_valid) begin
                    for (int k = 0; k < P_OC; k++)
                        acc[k] <= acc_next[k];
                end
                // not stalled: either nothing is held or it is being taken now
                out_valid <= psum_valid & psum_last;
                if (psum_valid & psum_last)
                    out_data <= out_next;
            end
        end
    end

endmodule

// File: tb/tb_pwc_pe_acc.sv
module tb_pwc_pe_acc;

    localparam int D  = 8;
    localparam int PC = 32;
    localparam int PO = 4;
    localparam int GW = 4;
    localparam int FW = D * PC;
    localparam int WW = D * PC * PO;
    localparam int OW = D * PO;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [GW-1:0] cfg_num_groups = '0;
    logic [4:0]    cfg_shift = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [FW-1:0] in_feature = '0;
    logic [WW-1:0] in_weight = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] out_data;

    int errors = 0;
    int checks = 0;
    int n_push = 0;
    int n_pop = 0;

    logic [OW-1:0] expq[$];
    longint        m_acc[PO];
    int            m_cnt = 0;
    int            m_ng = 1;
    int            m_sh = 0;

    always #5 clk = ~clk;

    pwc_pe_acc dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_num_groups (cfg_num_groups),
        .cfg_shift      (cfg_shift),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_feature     (in_feature),
        .in_weight      (in_weight),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Reference requantiser: floor division by 2^sh after adding half.
    function automatic longint model_rq(input longint a, input int sh);
        longint d;
        longint q;
        d = longint'(1) << sh;
        if (sh > 0)
            a = a + d / 2;
        q = a / d;
        if ((a % d) != 0 && a < 0)
            q = q - 1;
        if (q > 127)
            q = 127;
        if (q < -128)
            q = -128;
`ifdef PWC_RELU_EN
        if (q < 0)
            q = 0;
`endif
        return q;
    endfunction

    task automatic model_accept(input logic [FW-1:0] f, input logic [WW-1:0] w);
        logic [OW-1:0] e;
        longint        r;
        if (m_cnt == 0) begin
            m_ng = (cfg_num_groups == 0) ? 1 : int'(cfg_num_groups);
            m_sh = int'(cfg_shift);
            for (int k = 0; k < PO; k++)
                m_acc[k] = 0;
        end
        for (int k = 0; k < PO; k++)
            for (int c = 0; c < PC; c++)
                m_acc[k] += longint'($signed(f[c*D +: D])) *
                            longint'($signed(w[(k*PC + c)*D +: D]));
        m_cnt++;
        if (m_cnt == m_ng) begin
            e = '0;
            for (int k = 0; k < PO; k++) begin
                r = model_rq(m_acc[k], m_sh);
                e[k*D +: D] = r[D-1:0];
            end
            expq.push_back(e);
            n_push++;
            m_cnt = 0;
        end
    endtask

    function automatic logic [FW-1:0] fill_f(input int v);
        logic [FW-1:0] r;
        logic [7:0]    b;
        b = v[7:0];
        for (int c = 0; c < PC; c++)
            r[c*D +: D] = b;
        return r;
    endfunction

    function automatic logic [WW-1:0] fill_w(input int v);
        logic [WW-1:0] r;
        logic [7:0]    b;
        b = v[7:0];
        for (int c = 0; c < PC * PO; c++)
            r[c*D +: D] = b;
        return r;
    endfunction

    function automatic logic [FW-1:0] rand_f();
        logic [FW-1:0] r;
        for (int i = 0; i < FW / 32; i++)
            r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [WW-1:0] rand_w();
        logic [WW-1:0] r;
        for (int i = 0; i < WW / 32; i++)
            r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Present a beat, wait (bounded) until it is taken, update the model.
    // Returns 1 time unit after the accepting edge.
    task automatic send_beat(input logic [FW-1:0] f, input logic [WW-1:0] w);
        int n;
        n = 0;
        in_valid   = 1'b1;
        in_feature = f;
        in_weight  = w;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("beat_accept_wait", in_ready, 1);
        if (in_ready)
            model_accept(f, w);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, out_valid, 1);
    endtask

    task automatic chk_lanes(input string tag, input int e);
        for (int k = 0; k < PO; k++)
            chk(tag, $signed(out_data[k*D +: D]), e);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        in_valid = 1'b0;
        while (expq.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(tag, expq.size(), 0);
    endtask

    // Every handshaken result is compared with the next model result.
    always @(negedge clk) begin
        logic [OW-1:0] e;
        if (!reset && out_valid && out_ready) begin
            e = (expq.size() > 0) ? expq.pop_front() : 'x;
            n_pop++;
            chk("out_data", out_data, e);
        end
    end

    initial begin
        logic [FW-1:0] f;
        logic [WW-1:0] w;
        logic [OW-1:0] held;
        int            ng;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_out_valid", out_valid, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);

        // single group, ones: lanes 32, visible two edges after accept
        cfg_num_groups = 4'd1;
        cfg_shift      = 5'd0;
        send_beat(fill_f(1), fill_w(1));
        in_valid = 1'b0;
        chk("lat_edge0", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_edge1", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_edge2", out_valid, 1);
        chk_lanes("ones_lane", 32);
        @(posedge clk); #1;

        // four groups, shift 3; mid-tile cfg changes must be ignored
        cfg_num_groups = 4'd4;
        cfg_shift      = 5'd3;
        send_beat(fill_f(2), fill_w(3));
        cfg_num_groups = 4'd1;
        cfg_shift      = 5'd0;
        send_beat(fill_f(2), fill_w(3));
        send_beat(fill_f(2), fill_w(3));
        in_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("grp4_no_early_valid", out_valid, 0);
        end
        @(posedge clk); #1;
        send_beat(fill_f(2), fill_w(3));
        in_valid = 1'b0;
        wait_valid("grp4_valid");
        chk_lanes("grp4_lane", 96);
        @(posedge clk); #1;

        // rounding: acc 5 and -5 with shift 1
        cfg_num_groups = 4'd1;
        cfg_shift      = 5'd1;
        f = '0;
        w = '0;
        f[7:0]        = 8'd5;
        w[7:0]        = 8'd1;
        w[PC*D +: D]  = 8'hFF;
        send_beat(f, w);
        in_valid = 1'b0;
        wait_valid("round_valid");
        chk("round_pos", $signed(out_data[7:0]), 3);
        chk("round_neg", $signed(out_data[15:8]), -2);
        chk("round_zero", out_data[31:16], 0);
        @(posedge clk); #1;

        // saturation both ways
        cfg_shift = 5'd0;
        send_beat(fill_f(-128), fill_w(127));
        in_valid = 1'b0;
        wait_valid("sat_neg_valid");
`ifdef PWC_RELU_EN
        chk_lanes("sat_neg_lane", 0);
`else
        chk_lanes("sat_neg_lane", -128);
`endif
        @(posedge clk); #1;
        send_beat(fill_f(127), fill_w(127));
        in_valid = 1'b0;
        wait_valid("sat_pos_valid");
        chk_lanes("sat_pos_lane", 127);
        @(posedge clk); #1;
        drain("drain_directed");

        // streaming with a 10-cycle output stall
        cfg_num_groups = 4'd1;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    cfg_shift = 5'($urandom_range(6, 16));
                    send_beat(rand_f(), rand_w());
                end
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                held = out_data;
                chk("stall_out_valid", out_valid, 1);
                repeat (10) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_data_hold", out_data, held);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_stream");

        // random tiles with random group counts and ignored mid-tile cfg noise
        for (int t = 0; t < 8; t++) begin
            ng = $urandom_range(0, 3);
            cfg_num_groups = GW'(ng);
            cfg_shift      = 5'($urandom_range(8, 18));
            for (int b = 0; b < ((ng == 0) ? 1 : ng); b++) begin
                if (b > 0) begin
                    cfg_num_groups = GW'($urandom_range(0, 15));
                    cfg_shift      = 5'($urandom_range(0, 24));
                end
                send_beat(rand_f(), rand_w());
                if ($urandom_range(0, 1) == 1) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
        end
        drain("drain_random");

        // reset after two of four groups discards the partial tile
        cfg_num_groups = 4'd4;
        cfg_shift      = 5'd3;
        send_beat(fill_f(1), fill_w(1));
        send_beat(fill_f(1), fill_w(1));
        in_valid = 1'b0;
        reset    = 1'b1;
        m_cnt    = 0;
        @(negedge clk);
        chk("rst_mid_out_valid", out_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_in_ready", in_ready, 1);
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_no_output", out_valid, 0);
        end
        @(posedge clk); #1;
        for (int b = 0; b < 4; b++)
            send_beat(fill_f(2), fill_w(1));
        in_valid = 1'b0;
        wait_valid("rst_mid_valid");
        chk_lanes("rst_mid_lane", 32);
        @(posedge clk); #1;
        drain("drain_final");
        chk("result_count", n_pop, n_push);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
